// File: rtl/cam_pkg.sv
// Shared types and default geometry for the camera capture front end.
package cam_pkg;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    SKIP     = 2'd1,
    ACTIVE   = 2'd2
  } cam_state_e;

  localparam int unsigned CAM_H_ACTIVE    = 640;
  localparam int unsigned CAM_V_ACTIVE    = 480;
  localparam int unsigned CAM_SKIP_FRAMES = 10;

endpackage

// File: rtl/cam_capture_edge_det.sv
// Registers a 1-bit input and flags its rising and falling edges against the
// value held from the previous clock edge.
module edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic d_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) d_q <= 1'b0;
    else       d_q <= d_i;
  end

  assign rise_c_o = d_i & ~d_q;
  assign fall_c_o = ~d_i & d_q;

endmodule

// File: rtl/cam_capture.sv
// UYVY luma extractor: waits for cfg_done, skips start-up frames, then writes
// one luma byte per pixel, clamped to H_ACTIVE x V_ACTIVE. Build option:
// CAM_CAPTURE_TESTPAT_EN replaces the pixel data with pix_cnt ^ line_cnt.
module cam_capture
  import cam_pkg::*;
#(
  parameter int unsigned SKIP_FRAMES = CAM_SKIP_FRAMES,
  parameter int unsigned H_ACTIVE    = CAM_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = CAM_V_ACTIVE
) (
  input  logic       cam_pclk,
  input  logic       rst,
  input  logic       cfg_done,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] din,
  output logic       wr_en_o,
  output logic [7:0] dout,
  output logic       frame_start_o,
  output logic       capturing_o,
  output logic       line_err_o
);

  localparam int unsigned PW = $clog2(H_ACTIVE + 1);
  localparam int unsigned LW = $clog2(V_ACTIVE + 1);
  localparam int unsigned CW = $clog2(H_ACTIVE + 2);

  cam_state_e state_q, state_d;

  logic          vs_fall, href_fall, unused_vs_rise, unused_href_rise;
  logic          restart_c;
  logic [3:0]    skip_nxt_c;
  logic [3:0]    skip_cnt_q, skip_cnt_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [CW-1:0] luma_cnt_q, luma_cnt_d;
  logic          ph_q, ph_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    dout_q, dout_d;
  logic          frame_start_q, frame_start_d;
  logic          capturing_q, capturing_d;
  logic          line_err_q, line_err_d;

  edge_det u_href_edge (
    .clk_i    (cam_pclk),
    .rst_i    (rst),
    .d_i      (href_i),
    .rise_c_o (unused_href_rise),
    .fall_c_o (href_fall)
  );

  edge_det u_vsync_edge (
    .clk_i    (cam_pclk),
    .rst_i    (rst),
    .d_i      (vsync_i),
    .rise_c_o (unused_vs_rise),
    .fall_c_o (vs_fall)
  );

`ifdef CAM_CAPTURE_TESTPAT_EN
  logic [7:0] unused_din;
  assign unused_din = din;
`endif

  assign skip_nxt_c = (skip_cnt_q == 4'hF) ? skip_cnt_q : skip_cnt_q + 4'd1;

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) state_q <= WAIT_CFG;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_CFG: if (cfg_done) state_d = SKIP;
      SKIP:     if (vs_fall && (skip_nxt_c >= 4'(SKIP_FRAMES))) state_d = ACTIVE;
      ACTIVE:   state_d = ACTIVE;
      default:  state_d = WAIT_CFG;
    endcase
    if (!cfg_done) state_d = WAIT_CFG;
  end

  // Frame restart is applied before the byte/line logic so a same-edge href
  // byte lands in line 0.
  always_comb begin
    restart_c     = vs_fall && cfg_done && (state_q == ACTIVE || state_d == ACTIVE);
    ph_d          = href_i ? ~ph_q : 1'b0;
    wr_en_d       = 1'b0;
    dout_d        = dout_q;
    frame_start_d = 1'b0;
    capturing_d   = (state_d == ACTIVE);
    line_err_d    = line_err_q;
    skip_cnt_d    = skip_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    luma_cnt_d    = luma_cnt_q;

    if (!cfg_done) begin
      skip_cnt_d = 4'd0;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      luma_cnt_d = '0;
    end else begin
      if (state_q == SKIP && vs_fall) skip_cnt_d = skip_nxt_c;
      if (restart_c) begin
        frame_start_d = 1'b1;
        pix_cnt_d     = '0;
        line_cnt_d    = '0;
        luma_cnt_d    = '0;
      end
      if (state_q == ACTIVE) begin
        if (href_i && ph_q) begin
          if (luma_cnt_d != CW'(H_ACTIVE + 1)) luma_cnt_d = luma_cnt_d + CW'(1);
          if (pix_cnt_d < PW'(H_ACTIVE) && line_cnt_d < LW'(V_ACTIVE)) begin
            wr_en_d = 1'b1;
`ifdef CAM_CAPTURE_TESTPAT_EN
            dout_d  = 8'(pix_cnt_d) ^ 8'(line_cnt_d);
`else
            dout_d  = din;
`endif
            pix_cnt_d = pix_cnt_d + PW'(1);
          end
        end
        if (href_fall && !restart_c) begin
          if (line_cnt_d < LW'(V_ACTIVE)) begin
            line_cnt_d = line_cnt_d + LW'(1);
            if (luma_cnt_q != CW'(H_ACTIVE)) line_err_d = 1'b1;
          end
          pix_cnt_d  = '0;
          luma_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      ph_q          <= 1'b0;
      skip_cnt_q    <= 4'd0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      luma_cnt_q    <= '0;
      wr_en_q       <= 1'b0;
      dout_q        <= 8'd0;
      frame_start_q <= 1'b0;
      capturing_q   <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      ph_q          <= ph_d;
      skip_cnt_q    <= skip_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      luma_cnt_q    <= luma_cnt_d;
      wr_en_q       <= wr_en_d;
      dout_q        <= dout_d;
      frame_start_q <= frame_start_d;
      capturing_q   <= capturing_d;
      line_err_q    <= line_err_d;
    end
  end

  assign wr_en_o       = wr_en_q;
  assign dout          = dout_q;
  assign frame_start_o = frame_start_q;
  assign capturing_o   = capturing_q;
  assign line_err_o    = line_err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a small window; expected luma bytes are
// queued as lines are driven and checked as the DUT writes them.
module tb_cam_capture;

  localparam int unsigned H = 16;
  localparam int unsigned V = 6;
  localparam int unsigned SKIP_N = 10;

  logic       cam_pclk = 1'b0;
  logic       rst      = 1'b1;
  logic       cfg_done = 1'b0;
  logic       vsync_i  = 1'b0;
  logic       href_i   = 1'b0;
  logic [7:0] din      = 8'd0;
  logic       wr_en_o;
  logic [7:0] dout;
  logic       frame_start_o;
  logic       capturing_o;
  logic       line_err_o;

  int         checks = 0;
  int         failures = 0;
  int         wr_count = 0;
  int         exp_writes = 0;
  int         exp_line = 0;
  int         frame_w0;
  bit         active = 1'b0;
  bit         exp_err = 1'b0;
  logic       prev_wr = 1'b0;
  logic [7:0] mon_exp;
  logic [7:0] exp_q[$];

  cam_capture #(
    .SKIP_FRAMES (SKIP_N),
    .H_ACTIVE    (H),
    .V_ACTIVE    (V)
  ) dut (
    .cam_pclk      (cam_pclk),
    .rst           (rst),
    .cfg_done      (cfg_done),
    .vsync_i       (vsync_i),
    .href_i        (href_i),
    .din           (din),
    .wr_en_o       (wr_en_o),
    .dout          (dout),
    .frame_start_o (frame_start_o),
    .capturing_o   (capturing_o),
    .line_err_o    (line_err_o)
  );

  always #5 cam_pclk = ~cam_pclk;

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge cam_pclk) begin
    if (wr_en_o === 1'b1) begin
      wr_count++;
      checks++;
      assert (prev_wr === 1'b0) else begin
        failures++;
        $error("FAIL back_to_back_write observed=%b expected=0", prev_wr);
      end
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_write dout=%02h expected=no_write", dout);
      end
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        checks++;
        assert (dout === mon_exp) else begin
          failures++;
          $error("FAIL dout observed=%02h expected=%02h", dout, mon_exp);
        end
      end
    end
    prev_wr = wr_en_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cam_pclk);
    #1;
  endtask

  task automatic queue_luma(input int i, input int widx);
    logic [7:0] b;
`ifdef CAM_CAPTURE_TESTPAT_EN
    b = 8'(widx) ^ 8'(exp_line);
`else
    b = 8'(i);
`endif
    exp_q.push_back(b);
    exp_writes++;
  endtask

  task automatic frame_edge(input logic exp_fs);
    vsync_i = 1'b1;
    step();
    step();
    vsync_i = 1'b0;
    @(posedge cam_pclk);
    @(negedge cam_pclk);
    chk("frame_start", 32'(frame_start_o), 32'(exp_fs));
    if (active) exp_line = 0;
  endtask

  task automatic send_line(input int n, input bit vs_first);
    int widx;
    widx = 0;
    if (vs_first) begin
      vsync_i = 1'b1;
      step();
      step();
    end
    for (int i = 0; i < n; i++) begin
      din    = 8'(i);
      href_i = 1'b1;
      if (i == 0 && vs_first) begin
        vsync_i  = 1'b0;
        exp_line = 0;
      end
      if (i % 2 == 1) begin
        if (active && exp_line < V && widx < H) queue_luma(i, widx);
        widx++;
      end
      @(posedge cam_pclk);
      if (i == 0 && vs_first) begin
        @(negedge cam_pclk);
        chk("frame_start_same_edge", 32'(frame_start_o), 32'd1);
      end else begin
        #1;
      end
    end
    href_i = 1'b0;
    step();
    if (active && exp_line < V) begin
      if (widx != H) exp_err = 1'b1;
      exp_line++;
    end
    step();
    step();
    chk("line_drain", 32'(exp_q.size()), 32'd0);
    chk("line_err", 32'(line_err_o), 32'(exp_err));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge cam_pclk);
    chk("rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_frame_start", 32'(frame_start_o), 32'd0);
    chk("rst_capturing", 32'(capturing_o), 32'd0);
    chk("rst_line_err", 32'(line_err_o), 32'd0);
    rst = 1'b0;
    step();

    // Start-up frames are skipped; the tenth vsync fall starts capture
    cfg_done = 1'b1;
    step();
    send_line(2 * H, 1'b0);
    for (int f = 0; f < SKIP_N - 1; f++) frame_edge(1'b0);
    chk("skip_capturing", 32'(capturing_o), 32'd0);
    frame_edge(1'b1);
    chk("active_capturing", 32'(capturing_o), 32'd1);
    active = 1'b1;
    exp_line = 0;
    @(negedge cam_pclk);
    chk("frame_start_single", 32'(frame_start_o), 32'd0);

    // One frame: exact, long and short lines, then extra lines past V
    frame_w0 = wr_count;
    send_line(2 * H, 1'b0);
    send_line(2 * H + 6, 1'b0);
    send_line(2 * H - 4, 1'b0);
    for (int l = 0; l < 7; l++) send_line(2 * H, 1'b0);
    chk("frame_writes", 32'(wr_count - frame_w0), 32'(H * (V - 1) + (H - 2)));

    // New frame restarts at line 0, including vsync fall coincident with href rise
    frame_edge(1'b1);
    send_line(2 * H, 1'b0);
    send_line(2 * H, 1'b1);

    // Abort mid-line when cfg_done drops
    for (int i = 0; i < 11; i++) begin
      din    = 8'(i);
      href_i = 1'b1;
      if (i % 2 == 1) queue_luma(i, i / 2);
      step();
    end
    din      = 8'd11;
    cfg_done = 1'b0;
    @(posedge cam_pclk);
    @(negedge cam_pclk);
    chk("abort_wr_en", 32'(wr_en_o), 32'd0);
    chk("abort_capturing", 32'(capturing_o), 32'd0);
    href_i = 1'b0;
    active = 1'b0;
    step();
    step();
    chk("abort_drain", 32'(exp_q.size()), 32'd0);

    // Re-enable: the skip sequence repeats in full
    cfg_done = 1'b1;
    step();
    for (int f = 0; f < SKIP_N - 1; f++) frame_edge(1'b0);
    chk("reskip_capturing", 32'(capturing_o), 32'd0);
    frame_edge(1'b1);
    chk("recapture", 32'(capturing_o), 32'd1);
    active = 1'b1;
    exp_line = 0;
    send_line(2 * H, 1'b0);

    repeat (3) step();
    chk("total_writes", 32'(wr_count), 32'(exp_writes));
    chk("line_err_sticky", 32'(line_err_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
